// File: rtl/lsu_requester_pkg.sv
// Shared types and constants for the load/store requester.
// Also holds the request fault classifier used by the top level.
package lsu_requester_pkg;

  typedef enum logic [2:0] {
    LSU_IDLE,
    LSU_STORE,
    LSU_LWAIT,
    LSU_RESP,
    LSU_TRAP
  } tLsuState;

  typedef struct packed {
    logic        dv;
    logic [4:0]  addr;
    logic [31:0] data;
  } tRegOp;

  localparam logic [2:0] cLsB  = 3'b000;
  localparam logic [2:0] cLsH  = 3'b001;
  localparam logic [2:0] cLsW  = 3'b010;
  localparam logic [2:0] cLsBU = 3'b100;
  localparam logic [2:0] cLsHU = 3'b101;

  localparam logic [1:0] cTrapNone     = 2'b00;
  localparam logic [1:0] cTrapLoadMis  = 2'b01;
  localparam logic [1:0] cTrapStoreMis = 2'b10;
  localparam logic [1:0] cTrapIllegal  = 2'b11;

  // Illegal encodings win over misalignment.
  function automatic logic [1:0] lsu_fault(input logic       is_store,
                                           input logic [2:0] funct3,
                                           input logic [1:0] ea_lo);
    logic illegal;
    logic misaligned;
    illegal    = (funct3 == 3'b011) || (funct3[2:1] == 2'b11) || (is_store && funct3[2]);
    misaligned = ((funct3[1:0] == 2'b01) && ea_lo[0]) ||
                 ((funct3[1:0] == 2'b10) && (ea_lo != 2'b00));
    if (illegal) return cTrapIllegal;
    if (misaligned) return is_store ? cTrapStoreMis : cTrapLoadMis;
    return cTrapNone;
  endfunction

endpackage

// File: rtl/lsu_requester_load_align.sv
// Load lane select and sign/zero extension of a RAM read word.
module lsu_load_align
  import lsu_requester_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  offset_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata_i[{offset_i, 3'b000} +: 8];
    half_sel = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    case (funct3_i)
      cLsB:    data_o = {{24{byte_sel[7]}}, byte_sel};
      cLsBU:   data_o = {24'h0, byte_sel};
      cLsH:    data_o = {{16{half_sel[15]}}, half_sel};
      cLsHU:   data_o = {16'h0, half_sel};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/lsu_requester.sv
// Single-outstanding load/store requester driving a word-wide data RAM port.
// Loads wait a fixed read latency, then return an aligned register write-back op.
module lsu_requester
  import lsu_requester_pkg::*;
#(
  parameter int cXLEN       = 32,
  parameter int cRamDepth   = 1024,
  parameter int cMemLatency = 1,
  localparam int cAW        = $clog2(cRamDepth)
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic              iReqValid,
  output logic              oReqReady,
  input  logic              iIsLoad,
  input  logic              iIsStore,
  input  logic [2:0]        iFunct3,
  input  logic [cXLEN-1:0]  iRs1,
  input  logic [cXLEN-1:0]  iRs2,
  input  logic [cXLEN-1:0]  iImm,
  input  logic [4:0]        iRdAddr,
  output logic              oMemEn,
  output logic              oMemWe,
  output logic [3:0]        oMemBe,
  output logic [cAW-1:0]    oMemAddr,
  output logic [cXLEN-1:0]  oMemWData,
  input  logic [cXLEN-1:0]  iMemRData,
  output tRegOp             oRegOp,
  output logic              oStall,
  output logic              oTrap,
  output logic [1:0]        oTrapCause
);

  tLsuState         state_q;
  logic [2:0]       cnt_q;
  logic [2:0]       funct3_q;
  logic [1:0]       off_q;
  logic [4:0]       rd_q;
  logic             mem_en_q, mem_we_q, trap_q;
  logic [3:0]       mem_be_q;
  logic [cAW-1:0]   mem_addr_q;
  logic [cXLEN-1:0] mem_wdata_q;
  logic [1:0]       trap_cause_q;
  tRegOp            reg_op_q;

  logic [31:0]      ea_d;
  logic             accept_d;
  logic [1:0]       fault_d;
  logic [3:0]       be_d;
  logic [31:0]      wdata_d;
  logic [31:0]      load_data_d;
  logic             ea_unused;

  assign ea_d      = iRs1 + iImm;
  assign ea_unused = ^ea_d[31:cAW+2];
  assign oReqReady = (state_q == LSU_IDLE);
  assign accept_d  = iReqValid && oReqReady && (iIsLoad || iIsStore);
  assign fault_d   = lsu_fault(iIsStore, iFunct3, ea_d[1:0]);
  assign oStall    = (state_q != LSU_IDLE) || accept_d;

  always_comb begin
    be_d    = 4'b1111;
    wdata_d = iRs2;
    case (iFunct3)
      cLsB: begin
        be_d    = 4'b0001 << ea_d[1:0];
        wdata_d = {4{iRs2[7:0]}};
      end
      cLsH: begin
        be_d    = 4'b0011 << {ea_d[1], 1'b0};
        wdata_d = {2{iRs2[15:0]}};
      end
      default: ;
    endcase
  end

  lsu_load_align u_align (
    .rdata_i  (iMemRData),
    .offset_i (off_q),
    .funct3_i (funct3_q),
    .data_o   (load_data_d)
  );

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q      <= LSU_IDLE;
      cnt_q        <= '0;
      funct3_q     <= '0;
      off_q        <= '0;
      rd_q         <= '0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_be_q     <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      trap_q       <= 1'b0;
      trap_cause_q <= '0;
      reg_op_q     <= '0;
    end else begin
      // Pulse outputs default low; address/data hold their last value.
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      trap_q       <= 1'b0;
      trap_cause_q <= '0;
      reg_op_q     <= '0;
      case (state_q)
        LSU_IDLE: begin
          if (accept_d) begin
            funct3_q <= iFunct3;
            off_q    <= ea_d[1:0];
            rd_q     <= iRdAddr;
            if (fault_d != cTrapNone) begin
              state_q      <= LSU_TRAP;
              trap_q       <= 1'b1;
              trap_cause_q <= fault_d;
            end else if (iIsStore) begin
              state_q     <= LSU_STORE;
              mem_en_q    <= 1'b1;
              mem_we_q    <= 1'b1;
              mem_be_q    <= be_d;
              mem_addr_q  <= ea_d[cAW+1:2];
              mem_wdata_q <= wdata_d;
            end else begin
              state_q    <= LSU_LWAIT;
              cnt_q      <= 3'(cMemLatency);
              mem_en_q   <= 1'b1;
              mem_be_q   <= 4'b1111;
              mem_addr_q <= ea_d[cAW+1:2];
            end
          end
        end
        LSU_LWAIT: begin
          if (cnt_q == 3'd0) begin
            state_q       <= LSU_RESP;
            reg_op_q.dv   <= (rd_q != 5'd0);
            reg_op_q.addr <= rd_q;
            reg_op_q.data <= load_data_d;
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        default: state_q <= LSU_IDLE;
      endcase
    end
  end

  assign oMemEn     = mem_en_q;
  assign oMemWe     = mem_we_q;
  assign oMemBe     = mem_be_q;
  assign oMemAddr   = mem_addr_q;
  assign oMemWData  = mem_wdata_q;
  assign oTrap      = trap_q;
  assign oTrapCause = trap_cause_q;
  assign oRegOp     = reg_op_q;

endmodule

// File: tb/tb_lsu_requester.sv
// Directed bench for lsu_requester: instance 0 uses read latency 1, instance 1 latency 3,
// each backed by a small byte-enabled RAM model with a pipelined read.
module tb_lsu_requester;
  import lsu_requester_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        req_valid [2];
  logic        req_ready [2];
  logic        is_load   [2];
  logic        is_store  [2];
  logic [2:0]  funct3    [2];
  logic [31:0] rs1       [2];
  logic [31:0] rs2       [2];
  logic [31:0] imm       [2];
  logic [4:0]  rd        [2];
  logic        mem_en    [2];
  logic        mem_we    [2];
  logic [3:0]  mem_be    [2];
  logic [9:0]  mem_addr  [2];
  logic [31:0] mem_wdata [2];
  logic [31:0] mem_rdata [2];
  tRegOp       reg_op    [2];
  logic        stall     [2];
  logic        trap      [2];
  logic [1:0]  trap_cause[2];

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_dut
      localparam int cLat = (gi == 0) ? 1 : 3;
      logic [31:0] mem  [1024];
      logic [31:0] pipe [cLat];

      lsu_requester #(.cXLEN(32), .cRamDepth(1024), .cMemLatency(cLat)) u_dut (
        .iClk(clk), .iRst(rst),
        .iReqValid(req_valid[gi]), .oReqReady(req_ready[gi]),
        .iIsLoad(is_load[gi]), .iIsStore(is_store[gi]), .iFunct3(funct3[gi]),
        .iRs1(rs1[gi]), .iRs2(rs2[gi]), .iImm(imm[gi]), .iRdAddr(rd[gi]),
        .oMemEn(mem_en[gi]), .oMemWe(mem_we[gi]), .oMemBe(mem_be[gi]),
        .oMemAddr(mem_addr[gi]), .oMemWData(mem_wdata[gi]), .iMemRData(mem_rdata[gi]),
        .oRegOp(reg_op[gi]), .oStall(stall[gi]),
        .oTrap(trap[gi]), .oTrapCause(trap_cause[gi])
      );

      always @(posedge clk) begin
        if (mem_en[gi] && mem_we[gi]) begin
          for (int b = 0; b < 4; b++)
            if (mem_be[gi][b]) mem[mem_addr[gi]][8*b +: 8] <= mem_wdata[gi][8*b +: 8];
        end
        pipe[0] <= (mem_en[gi] && !mem_we[gi]) ? mem[mem_addr[gi]] : 32'h0;
        for (int k = 1; k < cLat; k++) pipe[k] <= pipe[k-1];
      end
      assign mem_rdata[gi] = pipe[cLat-1];
    end
  endgenerate

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic ld, input logic st,
                         input logic [2:0] f3, input logic [31:0] r1, input logic [31:0] im,
                         input logic [31:0] r2, input logic [4:0] rdv);
    req_valid[i] = v; is_load[i] = ld; is_store[i] = st; funct3[i] = f3;
    rs1[i] = r1; imm[i] = im; rs2[i] = r2; rd[i] = rdv;
  endtask

  task automatic clr_req(input int i);
    set_req(i, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0, 5'd0);
  endtask

  // Called just after a negedge with the block idle.
  task automatic do_store(input int i, input string tag, input logic [2:0] f3,
                          input logic [31:0] r1, input logic [31:0] im, input logic [31:0] r2,
                          input logic [31:0] exp_addr, input logic [31:0] exp_be,
                          input logic [31:0] exp_wdata);
    set_req(i, 1'b1, 1'b0, 1'b1, f3, r1, im, r2, 5'd0);
    #1 check({tag, "_stall_acc"}, stall[i], 1);
    @(negedge clk); clr_req(i);
    $display("store %s: addr=%h be=%b wdata=%h", tag, mem_addr[i], mem_be[i], mem_wdata[i]);
    check({tag, "_en"}, mem_en[i], 1);
    check({tag, "_we"}, mem_we[i], 1);
    check({tag, "_addr"}, mem_addr[i], exp_addr);
    check({tag, "_be"}, mem_be[i], exp_be);
    check({tag, "_wdata"}, mem_wdata[i], exp_wdata);
    check({tag, "_stall"}, stall[i], 1);
    check({tag, "_ready_busy"}, req_ready[i], 0);
    @(negedge clk);
    check({tag, "_we_end"}, mem_we[i], 0);
    check({tag, "_stall_end"}, stall[i], 0);
    check({tag, "_ready_end"}, req_ready[i], 1);
  endtask

  task automatic do_load(input int i, input int lat, input string tag, input logic [2:0] f3,
                         input logic [31:0] r1, input logic [31:0] im, input logic [4:0] rdv,
                         input logic [31:0] exp_addr, input logic exp_dv,
                         input logic [31:0] exp_data);
    set_req(i, 1'b1, 1'b1, 1'b0, f3, r1, im, 32'h0, rdv);
    #1 check({tag, "_stall_acc"}, stall[i], 1);
    @(negedge clk); clr_req(i);
    check({tag, "_en"}, mem_en[i], 1);
    check({tag, "_we"}, mem_we[i], 0);
    check({tag, "_be"}, mem_be[i], 4'b1111);
    check({tag, "_addr"}, mem_addr[i], exp_addr);
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      check({tag, "_en_wait"}, mem_en[i], 0);
      check({tag, "_dv_wait"}, reg_op[i].dv, 0);
      check({tag, "_ready_wait"}, req_ready[i], 0);
    end
    @(negedge clk);
    $display("load %s: dv=%b rd=%0d data=%h", tag, reg_op[i].dv, reg_op[i].addr, reg_op[i].data);
    check({tag, "_dv"}, reg_op[i].dv, exp_dv);
    if (exp_dv) begin
      check({tag, "_rd"}, reg_op[i].addr, rdv);
      check({tag, "_data"}, reg_op[i].data, exp_data);
    end
    @(negedge clk);
    check({tag, "_dv_end"}, reg_op[i].dv, 0);
    check({tag, "_ready_end"}, req_ready[i], 1);
    check({tag, "_stall_end"}, stall[i], 0);
  endtask

  task automatic do_trap(input int i, input string tag, input logic ld, input logic st,
                         input logic [2:0] f3, input logic [31:0] r1, input logic [31:0] im,
                         input logic [1:0] exp_cause);
    set_req(i, 1'b1, ld, st, f3, r1, im, 32'h0, 5'd1);
    #1 check({tag, "_stall_acc"}, stall[i], 1);
    @(negedge clk); clr_req(i);
    $display("trap %s: trap=%b cause=%b", tag, trap[i], trap_cause[i]);
    check({tag, "_trap"}, trap[i], 1);
    check({tag, "_cause"}, trap_cause[i], exp_cause);
    check({tag, "_no_en"}, mem_en[i], 0);
    @(negedge clk);
    check({tag, "_trap_end"}, trap[i], 0);
    check({tag, "_ready_end"}, req_ready[i], 1);
  endtask

  // Valid held high across a load and a following store.
  task automatic do_b2b(input int i, input int lat, input string tag,
                        input logic [31:0] x, input logic [31:0] y);
    int we_cnt;
    int dv_cnt;
    we_cnt = 0;
    dv_cnt = 0;
    do_store(i, {tag, "_pre"}, cLsW, 32'h100, 32'h0, x, 32'h40, 32'hF, x);
    set_req(i, 1'b1, 1'b1, 1'b0, cLsW, 32'h100, 32'h0, 32'h0, 5'd9);
    @(negedge clk);
    set_req(i, 1'b1, 1'b0, 1'b1, cLsW, 32'h100, 32'h4, y, 5'd0);
    for (int c = 1; c <= lat + 2; c++) begin
      if (c > 1) @(negedge clk);
      check({tag, "_ready_low"}, req_ready[i], 0);
      we_cnt += int'(mem_we[i]);
      dv_cnt += int'(reg_op[i].dv);
      if (c == lat + 2) check({tag, "_load_data"}, reg_op[i].data, x);
    end
    @(negedge clk);
    check({tag, "_ready_idle"}, req_ready[i], 1);
    check({tag, "_stall_acc"}, stall[i], 1);
    @(negedge clk); clr_req(i);
    check({tag, "_st_we"}, mem_we[i], 1);
    check({tag, "_st_addr"}, mem_addr[i], 32'h41);
    check({tag, "_st_wdata"}, mem_wdata[i], y);
    we_cnt += int'(mem_we[i]);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      we_cnt += int'(mem_we[i]);
      dv_cnt += int'(reg_op[i].dv);
    end
    $display("b2b %s: we_pulses=%0d dv_pulses=%0d", tag, we_cnt, dv_cnt);
    check({tag, "_we_count"}, we_cnt, 1);
    check({tag, "_dv_count"}, dv_cnt, 1);
    do_load(i, lat, {tag, "_readback"}, cLsW, 32'h104, 32'h0, 5'd10, 32'h41, 1'b1, y);
  endtask

  initial begin
    int dv_cnt;
    rst = 1'b1;
    clr_req(0);
    clr_req(1);
    @(negedge clk);
    @(negedge clk);
    check("rst_en", mem_en[0], 0);
    check("rst_we", mem_we[0], 0);
    check("rst_be", mem_be[0], 0);
    check("rst_addr", mem_addr[0], 0);
    check("rst_wdata", mem_wdata[0], 0);
    check("rst_regop", reg_op[0].data, 0);
    check("rst_trap", trap[0], 0);
    check("rst_stall", stall[0], 0);
    check("rst_ready", req_ready[0], 1);
    rst = 1'b0;
    @(negedge clk);

    set_req(0, 1'b1, 1'b0, 1'b0, cLsW, 32'h100, 32'h0, 32'h0, 5'd1);
    #1 check("ignored_stall", stall[0], 0);
    @(negedge clk); clr_req(0);
    check("ignored_ready", req_ready[0], 1);
    check("ignored_en", mem_en[0], 0);

    do_store(0, "sw_zero", cLsW, 32'h100, 32'h0, 32'h0, 32'h40, 32'hF, 32'h0);
    do_store(0, "sw", cLsW, 32'h100, 32'h4, 32'hDEADBEEF, 32'h41, 32'hF, 32'hDEADBEEF);
    do_store(0, "sb", cLsB, 32'h100, 32'h3, 32'h000000A5, 32'h40, 32'h8, 32'hA5A5A5A5);
    do_load(0, 1, "lb", cLsB, 32'h103, 32'h0, 5'd5, 32'h40, 1'b1, 32'hFFFFFFA5);
    do_load(0, 1, "lbu", cLsBU, 32'h103, 32'h0, 5'd6, 32'h40, 1'b1, 32'h000000A5);
    do_store(0, "sw_pat", cLsW, 32'h100, 32'h0, 32'h80017FFF, 32'h40, 32'hF, 32'h80017FFF);
    do_load(0, 1, "lh", cLsH, 32'h100, 32'h2, 5'd7, 32'h40, 1'b1, 32'hFFFF8001);
    do_load(0, 1, "lhu", cLsHU, 32'h100, 32'h2, 5'd8, 32'h40, 1'b1, 32'h00008001);
    do_load(0, 1, "lh_rd0", cLsH, 32'h100, 32'h2, 5'd0, 32'h40, 1'b0, 32'hFFFF8001);
    do_load(0, 1, "lh_lo", cLsH, 32'h100, 32'h0, 5'd11, 32'h40, 1'b1, 32'h00007FFF);
    do_load(0, 1, "lb_pos", cLsB, 32'h101, 32'h0, 5'd12, 32'h40, 1'b1, 32'h0000007F);
    do_load(0, 1, "lb_neg0", cLsB, 32'h100, 32'h0, 5'd13, 32'h40, 1'b1, 32'hFFFFFFFF);
    do_load(0, 1, "lw_negimm", cLsW, 32'h108, 32'hFFFFFFF8, 5'd14, 32'h40, 1'b1, 32'h80017FFF);
    do_load(0, 1, "lw_wrap", cLsW, 32'hFFFFF100, 32'h0, 5'd15, 32'h40, 1'b1, 32'h80017FFF);
    do_store(0, "sh_hi", cLsH, 32'h100, 32'h2, 32'h0000BEEF, 32'h40, 32'hC, 32'hBEEFBEEF);
    do_load(0, 1, "lw_after_sh", cLsW, 32'h100, 32'h0, 5'd31, 32'h40, 1'b1, 32'hBEEF7FFF);

    do_trap(0, "lw_mis", 1'b1, 1'b0, cLsW, 32'h100, 32'h2, cTrapLoadMis);
    do_trap(0, "sh_mis", 1'b0, 1'b1, cLsH, 32'h100, 32'h1, cTrapStoreMis);
    do_trap(0, "f3_011", 1'b1, 1'b0, 3'b011, 32'h100, 32'h0, cTrapIllegal);
    do_trap(0, "sbu_ill", 1'b0, 1'b1, cLsBU, 32'h100, 32'h0, cTrapIllegal);

    do_b2b(0, 1, "b2b_l1", 32'h11223344, 32'h55667788);

    set_req(0, 1'b1, 1'b1, 1'b0, cLsW, 32'h104, 32'h0, 32'h0, 5'd3);
    @(negedge clk); clr_req(0);
    check("rstmid_en_before", mem_en[0], 1);
    rst = 1'b1;
    #1;
    check("rstmid_en", mem_en[0], 0);
    check("rstmid_be", mem_be[0], 0);
    check("rstmid_addr", mem_addr[0], 0);
    check("rstmid_stall", stall[0], 0);
    check("rstmid_ready", req_ready[0], 1);
    check("rstmid_dv", reg_op[0].dv, 0);
    @(negedge clk);
    rst = 1'b0;
    dv_cnt = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      dv_cnt += int'(reg_op[0].dv);
    end
    $display("reset mid-load: late dv pulses=%0d", dv_cnt);
    check("rstmid_no_late_dv", dv_cnt, 0);
    do_load(0, 1, "post_rst_lw", cLsW, 32'h104, 32'h0, 5'd4, 32'h41, 1'b1, 32'h55667788);

    do_b2b(1, 3, "b2b_l3", 32'hCAFEF00D, 32'h0BADC0DE);
    do_load(1, 3, "l3_lhu", cLsHU, 32'h106, 32'h0, 5'd20, 32'h41, 1'b1, 32'h00000BAD);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
